// File: rtl/l_sync_weight_bank.sv
// Double-buffered I/Q tap-weight store for the long-preamble sync correlator.
// Weights stream serially into a shadow bank; a commit copies them to the active bank.
module l_sync_weight_bank #(
    parameter int N_TAPS = 16,
    parameter int W_BITS = 2,
    parameter logic [N_TAPS*W_BITS-1:0] DEF_I = 32'h5F7FF5F5,
    parameter logic [N_TAPS*W_BITS-1:0] DEF_Q = 32'h55FFD557
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [W_BITS-1:0]          wr_i,
    input  logic [W_BITS-1:0]          wr_q,
    input  logic                       commit,
    input  logic                       abort,
    input  logic                       restore_def,
    input  logic                       corr_busy,
    output logic [N_TAPS*W_BITS-1:0]   I_W,
    output logic [N_TAPS*W_BITS-1:0]   Q_W,
    output logic                       commit_pend,
    output logic                       cmd_err,
    output logic [7:0]                 commit_cnt,
    output logic [1:0]                 state_dbg
);

    localparam int BW = N_TAPS * W_BITS;
    localparam int CW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CW-1:0] LAST_TAP = CW'(N_TAPS - 1);

    // Encoding is visible on state_dbg: 0 IDLE, 1 LOAD, 2 FULL, 3 PEND.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;
    localparam logic [1:0] S_PEND = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] sh_i;
    logic [BW-1:0] sh_q;
    logic          beat;

    // Handshake: a beat transfers on a rising edge where wr_valid and wr_ready are both 1.
    assign wr_ready  = (state == S_IDLE) || (state == S_LOAD);
    assign beat      = wr_valid & wr_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            I_W         <= DEF_I;
            Q_W         <= DEF_Q;
            sh_i        <= DEF_I;
            sh_q        <= DEF_Q;
            state       <= S_IDLE;
            cnt         <= '0;
            commit_pend <= 1'b0;
            cmd_err     <= 1'b0;
            commit_cnt  <= 8'd0;
        end else begin
            cmd_err <= 1'b0;
            if (restore_def) begin
                I_W         <= DEF_I;
                Q_W         <= DEF_Q;
                sh_i        <= DEF_I;
                sh_q        <= DEF_Q;
                state       <= S_IDLE;
                cnt         <= '0;
                commit_pend <= 1'b0;
            end else if (abort) begin
                // Abort always swallows any same-cycle commit or beat; in IDLE nothing else changes.
                if (state != S_IDLE) begin
                    state       <= S_IDLE;
                    cnt         <= '0;
                    commit_pend <= 1'b0;
                end
            end else if (commit && (state == S_IDLE || state == S_LOAD)) begin
                cmd_err <= 1'b1;
            end else begin
                case (state)
                    S_IDLE, S_LOAD: begin
                        if (beat) begin
                            for (int k = 0; k < N_TAPS; k++) begin
                                if (CW'(k) == cnt) begin
                                    sh_i[k*W_BITS +: W_BITS] <= wr_i;
                                    sh_q[k*W_BITS +: W_BITS] <= wr_q;
                                end
                            end
                            if (cnt == LAST_TAP) begin
                                state <= S_FULL;
                                cnt   <= '0;
                            end else begin
                                state <= S_LOAD;
                                cnt   <= cnt + CW'(1);
                            end
                        end
                    end
                    S_FULL: begin
                        if (commit) begin
                            if (!corr_busy) begin
                                I_W        <= sh_i;
                                Q_W        <= sh_q;
                                commit_cnt <= commit_cnt + 8'd1;
                                state      <= S_IDLE;
                            end else begin
                                state       <= S_PEND;
                                commit_pend <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (!corr_busy) begin
                            I_W         <= sh_i;
                            Q_W         <= sh_q;
                            commit_cnt  <= commit_cnt + 8'd1;
                            commit_pend <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule
